// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the boot-time SPI flash to ramio copier.
package flash_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        READ_BYTE,
        START_WRITE,
        WAIT_WRITE,
        DONE
    } state_e;

    localparam logic [7:0] FlashCmdRead = 8'h03;
    localparam int         SpiBitCycles = 2;

    // Byte address of word 'index' in a word-addressed region starting at 'base'; wraps mod 2^32.
    function automatic logic [31:0] word_address(input logic [31:0] base, input logic [31:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/flash_loader_if.sv
// Flash pins and ramio request port of the loader, bundled with loader/peer modports.
interface flash_loader_if;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_miso;
    logic        flash_cs_n;
    logic        ramio_enable;
    logic [2:0]  ramio_read_type;
    logic [1:0]  ramio_write_type;
    logic [31:0] ramio_address;
    logic [31:0] ramio_data_in;
    logic        ramio_busy;

    modport master (
        output flash_clk, flash_mosi, flash_cs_n,
        output ramio_enable, ramio_read_type, ramio_write_type, ramio_address, ramio_data_in,
        input  flash_miso, ramio_busy
    );

    modport slave (
        input  flash_clk, flash_mosi, flash_cs_n,
        input  ramio_enable, ramio_read_type, ramio_write_type, ramio_address, ramio_data_in,
        output flash_miso, ramio_busy
    );
endinterface

// File: rtl/flash_spi_shifter.sv
// Mode-0 SPI bit engine: shifts a TxBits header out MSB first, then keeps clocking and
// assembles incoming bytes; stall freezes it in the low phase of the current bit.
module flash_spi_shifter
    import flash_loader_pkg::*;
#(
    parameter int TxBits = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [TxBits-1:0] tx_data,
    input  logic              run,
    input  logic              stall,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [7:0]        rx_byte,
    output logic              byte_tick
);

    localparam int                PhaseW    = (SpiBitCycles > 2) ? $clog2(SpiBitCycles) : 1;
    localparam logic [PhaseW-1:0] LastPhase = PhaseW'(SpiBitCycles - 1);
    localparam logic [PhaseW-1:0] RisePhase = PhaseW'(SpiBitCycles - 2);

    logic [PhaseW-1:0] phase;
    logic [2:0]        bit_idx;
    logic [TxBits-1:0] tx_sh;
    logic              step;

    assign step      = run && !stall;
    // rx_byte is already complete during the high phase of the eighth bit.
    assign byte_tick = step && (phase == LastPhase) && (bit_idx == 3'd7);
    assign mosi      = tx_sh[TxBits-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= '0;
            bit_idx <= '0;
            tx_sh   <= '0;
            rx_byte <= '0;
            sclk    <= 1'b0;
        end else if (clear) begin
            phase   <= '0;
            bit_idx <= '0;
            tx_sh   <= tx_data;
            rx_byte <= '0;
            sclk    <= 1'b0;
        end else if (step) begin
            if (phase == LastPhase) begin
                phase   <= '0;
                bit_idx <= bit_idx + 3'd1;
                tx_sh   <= {tx_sh[TxBits-2:0], 1'b0};
                sclk    <= 1'b0;
            end else begin
                phase <= phase + PhaseW'(1);
                if (phase == RisePhase) begin
                    sclk    <= 1'b1;
                    rx_byte <= {rx_byte[6:0], miso};
                end
            end
        end
    end

endmodule

// File: rtl/flash_loader.sv
// Boot copier: reads TransferByteCount bytes from SPI flash (READ 0x03) into ramio, word by word.
// Define FLASH_LOADER_CHECKSUM_EN to build the running 32-bit sum of written words.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int          TransferByteCount = 256,
    parameter logic [23:0] FlashStartAddress = 24'd0,
    parameter logic [31:0] RamBaseAddress    = 32'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [31:0]    checksum,
    flash_loader_if.master bus
);

    localparam int             WordCount = TransferByteCount / 4;
    localparam int             CntW      = $clog2(WordCount) + 1;
    localparam logic [CntW-1:0] LastWord = CntW'(WordCount - 1);

    state_e          state, state_nx;
    logic            busy_nx, done_nx;
    logic            cs_n, cs_n_nx;
    logic            en, en_nx;
    logic [1:0]      wtype, wtype_nx;
    logic [31:0]     addr, addr_nx;
    logic [31:0]     wdata, wdata_nx;
    logic [31:0]     word, word_nx;
    logic [CntW-1:0] word_cnt, word_cnt_nx;
    logic [1:0]      byte_cnt, byte_cnt_nx;
    logic            accept, write_issue;
    logic            spi_run, spi_stall, byte_tick;
    logic [7:0]      rx_byte;
    logic            sclk, mosi;

    assign spi_run     = (state != IDLE) && (state != DONE);
    assign spi_stall   = (state == START_WRITE) || (state == WAIT_WRITE);
    assign write_issue = (state == START_WRITE) && !bus.ramio_busy;

    flash_spi_shifter #(.TxBits(32)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .tx_data   ({FlashCmdRead, FlashStartAddress}),
        .run       (spi_run),
        .stall     (spi_stall),
        .miso      (bus.flash_miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .rx_byte   (rx_byte),
        .byte_tick (byte_tick)
    );

    always_comb begin
        state_nx    = state;
        busy_nx     = busy;
        done_nx     = done;
        cs_n_nx     = cs_n;
        en_nx       = en;
        wtype_nx    = wtype;
        addr_nx     = addr;
        wdata_nx    = wdata;
        word_nx     = word;
        word_cnt_nx = word_cnt;
        byte_cnt_nx = byte_cnt;
        accept      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept      = 1'b1;
                    state_nx    = SEND_CMD;
                    cs_n_nx     = 1'b0;
                    busy_nx     = 1'b1;
                    done_nx     = 1'b0;
                    word_cnt_nx = '0;
                    byte_cnt_nx = '0;
                end
            end
            SEND_CMD: begin
                if (byte_tick) state_nx = SEND_ADDR;
            end
            SEND_ADDR: begin
                if (byte_tick) begin
                    byte_cnt_nx = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd2) begin
                        byte_cnt_nx = '0;
                        state_nx    = READ_BYTE;
                    end
                end
            end
            READ_BYTE: begin
                // Little-endian packing: the first byte ends up in bits [7:0].
                if (byte_tick) begin
                    word_nx     = {rx_byte, word[31:8]};
                    byte_cnt_nx = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) state_nx = START_WRITE;
                end
            end
            START_WRITE: begin
                if (write_issue) begin
                    en_nx    = 1'b1;
                    wtype_nx = 2'b11;
                    addr_nx  = word_address(RamBaseAddress, 32'(word_cnt));
                    wdata_nx = word;
                    state_nx = WAIT_WRITE;
                end
            end
            WAIT_WRITE: begin
                if (!bus.ramio_busy) begin
                    en_nx       = 1'b0;
                    wtype_nx    = 2'b00;
                    word_cnt_nx = word_cnt + CntW'(1);
                    if (word_cnt == LastWord) begin
                        cs_n_nx  = 1'b1;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = DONE;
                    end else begin
                        state_nx = READ_BYTE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            en       <= 1'b0;
            wtype    <= 2'b00;
            addr     <= '0;
            wdata    <= '0;
            word     <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            cs_n     <= cs_n_nx;
            en       <= en_nx;
            wtype    <= wtype_nx;
            addr     <= addr_nx;
            wdata    <= wdata_nx;
            word     <= word_nx;
            word_cnt <= word_cnt_nx;
            byte_cnt <= byte_cnt_nx;
        end
    end

`ifdef FLASH_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           checksum <= '0;
        else if (accept)      checksum <= '0;
        else if (write_issue) checksum <= checksum + word;
    end
`else
    assign checksum = '0;
`endif

    assign bus.flash_clk        = sclk;
    assign bus.flash_mosi       = mosi;
    assign bus.flash_cs_n       = cs_n;
    assign bus.ramio_enable     = en;
    assign bus.ramio_read_type  = 3'b000;
    assign bus.ramio_write_type = wtype;
    assign bus.ramio_address    = addr;
    assign bus.ramio_data_in    = wdata;

endmodule
